sram_bank_array: RTL and testbench

Parametrised banked SRAM array for the memory controller, built from SRAM1RW1024x8 macros arranged as NBANK banks of DW/8 byte lanes. It decodes a flat word address into a one-hot bank select, drives per-macro chip-select, write-enable and output-enable, and steers read data through a gated AND-OR tree. A valid/ready request port and a backpressured read-response port with a single-entry hold register add the sequencing a bare macro wrapper lacks. Sits between the memctrl command path and the macro grid.

---
 rtl/sram_bank_array.sv | 197 +++++++++++++++++++
 tb/tb_sram_bank_array.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_array.sv
// -----------------------------------------------------------------------------
// sram_bank_array
//   Banked SRAM array of NBANK x (DW/8) SRAM1RW1024x8 macros. It decodes a flat
//   word address into a bank select and drives per-macro CSB/WEB/OEB. Read data
//   passes through an OEB-gated AND-OR tree to a backpressured response port.
//   A single-entry hold register keeps a read result that the consumer has not
//   yet taken.
//
//   Optional feature: define SRAM_ARRAY_OREG_EN to register the read mux output.
//   This adds one cycle of read latency.
//
// Ports
//   CLK        in   clock (also every macro CE)
//   RST        in   synchronous active-high reset
//   REQ_VALID  in   request present
//   REQ_READY  out  request accepted when REQ_VALID & REQ_READY
//   REQ_WE     in   1 = write, 0 = read
//   REQ_ADDR   in   [9:0] row, [10+BAW-1:10] bank index
//   REQ_BE     in   per-lane byte enable (writes)
//   REQ_WDATA  in   write data, lane k = bits [8k+7:8k]
//   RSP_VALID  out  read data valid
//   RSP_READY  in   consumer takes data when RSP_VALID & RSP_READY
//   RSP_RDATA  out  read data
// -----------------------------------------------------------------------------

// Behavioural model of the 1024x8 single-port synchronous macro.
module SRAM1RW1024x8 (
   input  logic [9:0] A,
   input  logic       CE,
   input  logic       WEB,
   input  logic       OEB,
   input  logic       CSB,
   input  logic [7:0] I,
   output logic [7:0] O
);
   logic [7:0] mem_q [1024];
   logic [7:0] dout_q;

   always_ff @(posedge CE) begin
      if (!CSB) begin
         if (!WEB) mem_q[A] <= I;
         else      dout_q   <= mem_q[A];
      end
   end

   assign O = OEB ? '0 : dout_q;
endmodule

module sram_bank_array #(
   parameter int NBANK = 64,
   parameter int DW    = 8
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           REQ_VALID,
   output logic                           REQ_READY,
   input  logic                           REQ_WE,
   input  logic [10+$clog2(NBANK)-1:0]    REQ_ADDR,
   input  logic [DW/8-1:0]                REQ_BE,
   input  logic [DW-1:0]                  REQ_WDATA,
   output logic                           RSP_VALID,
   input  logic                           RSP_READY,
   output logic [DW-1:0]                  RSP_RDATA
);
   localparam int BAW = $clog2(NBANK);
   localparam int NL  = DW / 8;

   logic                  accept;
   logic [BAW-1:0]        req_bank;
   logic [NBANK*NL-1:0]   csb;
   logic [NBANK*NL-1:0]   oeb;
   logic                  web;
   logic [NBANK*DW-1:0]   macro_o;
   logic [DW-1:0]         mux_data;

   logic                  rd_pend_q, rd_pend_d;
   logic [BAW-1:0]        rd_bank_q, rd_bank_d;
   logic                  hold_valid_q, hold_valid_d;
   logic [DW-1:0]         hold_data_q, hold_data_d;
`ifdef SRAM_ARRAY_OREG_EN
   logic                  out_valid_q, out_valid_d;
   logic [DW-1:0]         out_data_q, out_data_d;
   logic                  out_load;
`endif

   assign req_bank = REQ_ADDR[10 +: BAW];
   assign accept   = REQ_VALID & REQ_READY;
   assign web      = ~(accept & REQ_WE);

   // Macro grid: bank b, lane k at flat index b*NL+k.
   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      for (genvar k = 0; k < NL; k++) begin : g_lane
         logic [7:0] mo;
         SRAM1RW1024x8 u_macro (
            .A   (REQ_ADDR[9:0]),
            .CE  (CLK),
            .WEB (web),
            .OEB (oeb[b*NL+k]),
            .CSB (csb[b*NL+k]),
            .I   (REQ_WDATA[8*k +: 8]),
            .O   (mo)
         );
         assign macro_o[b*DW + 8*k +: 8] = mo & {8{~oeb[b*NL+k]}};
      end
   end

   always_comb begin
      csb = '1;
      oeb = '1;
      for (int unsigned b = 0; b < NBANK; b++) begin
         for (int unsigned k = 0; k < NL; k++) begin
            csb[b*NL+k] = ~(accept & (req_bank == BAW'(b)) & (~REQ_WE | REQ_BE[k]));
            oeb[b*NL+k] = ~(rd_pend_q & (rd_bank_q == BAW'(b)));
         end
      end
   end

   // OR across banks; only the bank with OEB low contributes non-zero data.
   always_comb begin
      mux_data = '0;
      for (int unsigned b = 0; b < NBANK; b++) begin
         mux_data = mux_data | macro_o[b*DW +: DW];
      end
   end

   always_comb begin
      rd_pend_d = accept & ~REQ_WE;
      rd_bank_d = rd_bank_q;
      if (accept && !REQ_WE) rd_bank_d = req_bank;
   end

`ifdef SRAM_ARRAY_OREG_EN
   // The output register drains the hold (skid) entry before it takes new
   // mux data. The hold entry is only filled while the output stalls.
   assign out_load = ~out_valid_q | RSP_READY;

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      if (out_load) begin
         if (hold_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = hold_data_q;
            hold_valid_d = 1'b0;
         end else begin
            out_valid_d = rd_pend_q;
            out_data_d  = mux_data;
         end
      end else if (rd_pend_q) begin
         hold_valid_d = 1'b1;
         hold_data_d  = mux_data;
      end
   end

   assign REQ_READY = ~RST & ~hold_valid_q & ~(out_valid_q & ~RSP_READY & rd_pend_q);
   assign RSP_VALID = out_valid_q;
   assign RSP_RDATA = out_data_q;
`else
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      if (RSP_READY) hold_valid_d = 1'b0;
      if (rd_pend_q && !RSP_READY) begin
         hold_valid_d = 1'b1;
         hold_data_d  = mux_data;
      end
   end

   assign REQ_READY = ~RST & ~hold_valid_q & ~(rd_pend_q & ~RSP_READY);
   assign RSP_VALID = rd_pend_q | hold_valid_q;
   assign RSP_RDATA = hold_valid_q ? hold_data_q : mux_data;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_pend_q    <= 1'b0;
         rd_bank_q    <= '0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
`ifdef SRAM_ARRAY_OREG_EN
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
`endif
      end else begin
         rd_pend_q    <= rd_pend_d;
         rd_bank_q    <= rd_bank_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
`ifdef SRAM_ARRAY_OREG_EN
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
`endif
      end
   end
endmodule

// File: tb/tb_sram_bank_array.sv
module tb_sram_bank_array;
   localparam int NBANK = 64;
   localparam int DW    = 32;
   localparam int NL    = DW / 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic          REQ_VALID;
   logic          REQ_READY;
   logic          REQ_WE;
   logic [15:0]   REQ_ADDR;
   logic [NL-1:0] REQ_BE;
   logic [DW-1:0] REQ_WDATA;
   logic          RSP_VALID;
   logic          RSP_READY;
   logic [DW-1:0] RSP_RDATA;

   sram_bank_array #(.NBANK(NBANK), .DW(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_WE    (REQ_WE),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_BE    (REQ_BE),
      .REQ_WDATA (REQ_WDATA),
      .RSP_VALID (RSP_VALID),
      .RSP_READY (RSP_READY),
      .RSP_RDATA (RSP_RDATA)
   );

   always #5 CLK = ~CLK;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: word memory, queue of outstanding read results (data and
   // bank), and whether the head result has already waited one cycle or more.
   bit [31:0] mem [int];
   bit [31:0] exp_q [$];
   int        bank_q [$];
   bit        stalled;
   bit [15:0] pool [$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] merge(input bit [31:0] o, input bit [31:0] w, input bit [3:0] be);
      for (int k = 0; k < 4; k++) if (be[k]) o[8*k +: 8] = w[8*k +: 8];
      return o;
   endfunction

   task automatic step(input bit v, input bit we, input bit [15:0] a, input bit [3:0] be,
                       input bit [31:0] wd, input bit rr, input bit rs);
      bit exp_rdy;
      bit taken;
      logic [255:0] exp_oeb;
      @(negedge CLK);
      RST = rs; REQ_VALID = v; REQ_WE = we; REQ_ADDR = a; REQ_BE = be;
      REQ_WDATA = wd; RSP_READY = rr;
      #1;
      exp_rdy = !rs && !(exp_q.size() > 0 && (stalled || !rr));
      chk("req_ready", {255'd0, REQ_READY}, {255'd0, exp_rdy});
      chk("rsp_valid", {255'd0, RSP_VALID}, {255'd0, exp_q.size() > 0});
      chk("rsp_rdata", {224'd0, RSP_RDATA}, {224'd0, (exp_q.size() > 0) ? exp_q[0] : 32'd0});
      exp_oeb = '1;
      if (exp_q.size() > 0 && !stalled)
         for (int k = 0; k < NL; k++) exp_oeb[bank_q[0]*NL + k] = 1'b0;
      chk("oeb", {{(256-NBANK*NL){1'b0}}, dut.oeb}, {{(256-NBANK*NL){1'b0}}, exp_oeb[NBANK*NL-1:0]});
      taken = exp_q.size() > 0 && rr;
      if (taken) begin
         void'(exp_q.pop_front()); void'(bank_q.pop_front()); stalled = 1'b0;
      end else if (exp_q.size() > 0) begin
         stalled = 1'b1;
      end
      if (v && exp_rdy) begin
         if (we) begin
            if (mem.exists(a)) mem[a] = merge(mem[a], wd, be);
            else begin mem[a] = wd; pool.push_back(a); end
         end else begin
            exp_q.push_back(mem[a]); bank_q.push_back(int'(a[15:10]));
         end
      end
      if (rs) begin
         exp_q.delete(); bank_q.delete(); stalled = 1'b0;
      end
   endtask

   task automatic idle(input bit rr);
      step(1'b0, 1'b0, 16'd0, 4'd0, 32'd0, rr, 1'b0);
   endtask

   initial begin
      bit [15:0] a_a5, a_rmw, a_st, a_raw, a0, a63, a5;
      bit [15:0] ra;
      bit [3:0]  rbe;
      bit        rwe;
      RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_BE = '0;
      REQ_WDATA = '0; RSP_READY = 1'b1; stalled = 1'b0;

      // Reset
      step(0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 1, 1);
      idle(1);

      // Write 0xA5 to bank 3 row 0x010 then read it back
      a_a5 = {6'd3, 10'h010};
      step(1, 1, a_a5, 4'hF, 32'h000000A5, 1, 0);
      step(1, 0, a_a5, 4'h0, 32'h0, 1, 0);
      idle(1);
      chk("a5_literal", {224'd0, RSP_RDATA}, {224'd0, 32'h000000A5});

      // Byte-enable merge
      a_rmw = {6'd7, 10'h155};
      step(1, 1, a_rmw, 4'hF, 32'h11223344, 1, 0);
      step(1, 1, a_rmw, 4'b0101, 32'hFF00FF00, 1, 0);
      step(1, 0, a_rmw, 4'h0, 32'h0, 1, 0);
      idle(1);
      chk("be_literal", {224'd0, RSP_RDATA}, {224'd0, 32'h11003300});

      // Back-to-back reads of banks 0, 63, 5
      a0 = {6'd0, 10'h02A}; a63 = {6'd63, 10'h02A}; a5 = {6'd5, 10'h02A};
      step(1, 1, a0,  4'hF, 32'hC0DE0000, 1, 0);
      step(1, 1, a63, 4'hF, 32'hC0DE003F, 1, 0);
      step(1, 1, a5,  4'hF, 32'hC0DE0005, 1, 0);
      step(1, 0, a0,  4'h0, 32'h0, 1, 0);
      step(1, 0, a63, 4'h0, 32'h0, 1, 0);
      step(1, 0, a5,  4'h0, 32'h0, 1, 0);
      idle(1);

      // Stall for 3 cycles with a competing request held on the port
      a_st = {6'd9, 10'h100};
      step(1, 1, a_st, 4'hF, 32'h0000005A, 1, 0);
      step(1, 0, a_st, 4'h0, 32'h0, 1, 0);
      step(1, 0, a0, 4'h0, 32'h0, 0, 0);
      step(1, 0, a0, 4'h0, 32'h0, 0, 0);
      step(1, 0, a0, 4'h0, 32'h0, 0, 0);
      chk("stall_literal", {224'd0, RSP_RDATA}, {224'd0, 32'h0000005A});
      step(1, 0, a0, 4'h0, 32'h0, 1, 0);
      idle(1);

      // Read-after-write, same address, back to back
      a_raw = {6'd12, 10'h3FF};
      step(1, 1, a_raw, 4'hF, 32'h0000003C, 1, 0);
      step(1, 0, a_raw, 4'h0, 32'h0, 1, 0);
      idle(1);
      chk("raw_literal", {224'd0, RSP_RDATA}, {224'd0, 32'h0000003C});

      // Reset while a response is held; memory survives
      step(1, 0, a_a5, 4'h0, 32'h0, 1, 0);
      idle(0);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      idle(1);
      step(1, 0, a_a5, 4'h0, 32'h0, 1, 0);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         rwe = (pool.size() == 0) || ($urandom_range(0, 1) == 0);
         if (rwe) begin
            if ($urandom_range(0, 1) == 0 && pool.size() > 0) begin
               ra  = pool[$urandom_range(0, pool.size() - 1)];
               rbe = 4'($urandom_range(0, 15));
            end else begin
               ra  = 16'($urandom);
               rbe = mem.exists(ra) ? 4'($urandom_range(0, 15)) : 4'hF;
            end
         end else begin
            ra  = pool[$urandom_range(0, pool.size() - 1)];
            rbe = 4'($urandom_range(0, 15));
         end
         step($urandom_range(0, 3) != 0, rwe, ra, rbe, $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
      end
      idle(1);
      idle(1);
      idle(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
